// File: rtl/chroma_key_pkg.sv
// Shared definitions for the chroma-key controller: calibration state
// encoding, datapath widths and the threshold clamp helper.
package chroma_key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      ACCUM,
      APPLY
   } calib_state_e;

   localparam int EXCESS_W   = 10;
   localparam int ACC_W      = 23;
   localparam int THRESH_MIN = 0;
   localparam int THRESH_MAX = 255;

   // Saturate a wide signed value into the legal threshold range.
   function automatic logic signed [EXCESS_W-1:0] clamp_thresh(
      input logic signed [ACC_W-1:0] value
   );
      logic signed [EXCESS_W-1:0] result;
      if (value < $signed(ACC_W'(THRESH_MIN))) begin
         result = EXCESS_W'(THRESH_MIN);
      end else if (value > $signed(ACC_W'(THRESH_MAX))) begin
         result = EXCESS_W'(THRESH_MAX);
      end else begin
         result = value[EXCESS_W-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/green_excess_stage.sv
// First pixel-pipeline stage: registers the green excess e = g - r - b
// together with the pixel qualifier and coordinates so that they stay
// aligned with each other.
module green_excess_stage
   import chroma_key_pkg::*;
(
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       valid_in,
   input  logic [7:0]                 r_in,
   input  logic [7:0]                 g_in,
   input  logic [7:0]                 b_in,
   input  logic [10:0]                hcount_in,
   input  logic [9:0]                 vcount_in,
   output logic signed [EXCESS_W-1:0] excess_out,
   output logic                       valid_out,
   output logic [10:0]                hcount_out,
   output logic [9:0]                 vcount_out
);

   logic signed [EXCESS_W-1:0] excess_d, excess_q;
   logic                       valid_d, valid_q;
   logic [10:0]                hcount_d, hcount_q;
   logic [9:0]                 vcount_d, vcount_q;

   // Zero-extended components keep the signed difference exact over -510..255.
   always_comb begin
      excess_d = $signed({{(EXCESS_W-8){1'b0}}, g_in})
               - $signed({{(EXCESS_W-8){1'b0}}, r_in})
               - $signed({{(EXCESS_W-8){1'b0}}, b_in});
      valid_d  = valid_in;
      hcount_d = hcount_in;
      vcount_d = vcount_in;
   end

   // Stage register; invalid pixels flow through exactly like valid ones.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         excess_q <= '0;
         valid_q  <= 1'b0;
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         excess_q <= excess_d;
         valid_q  <= valid_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   assign excess_out = excess_q;
   assign valid_out  = valid_q;
   assign hcount_out = hcount_q;
   assign vcount_out = vcount_q;

endmodule

// File: rtl/chroma_key_ctrl.sv
// Chroma-key controller: two-stage green-excess mask pipeline plus a
// calibration sequencer that averages the green excess over a fixed
// background window of one frame and derives a new key threshold.
// Optional build macro CHROMA_KEY_STATS_EN adds a per-frame count of keyed
// pixels measured at the pipeline output.
module chroma_key_ctrl
   import chroma_key_pkg::*;
#(
   parameter int WIN_H0         = 576,
   parameter int WIN_V0         = 296,
   parameter int WIN_LOG2       = 6,
   parameter int MARGIN         = 16,
   parameter int DEFAULT_THRESH = 64
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       valid_in,
   input  logic [7:0]                 r_in,
   input  logic [7:0]                 g_in,
   input  logic [7:0]                 b_in,
   input  logic [10:0]                hcount_in,
   input  logic [9:0]                 vcount_in,
   input  logic                       calib_start_in,
   output logic                       mask_out,
   output logic                       valid_out,
   output logic [10:0]                hcount_out,
   output logic [9:0]                 vcount_out,
   output logic signed [EXCESS_W-1:0] threshold_out,
   output logic                       busy_out,
   output logic                       calib_done_out,
   output logic                       calib_fail_out
`ifdef CHROMA_KEY_STATS_EN
   ,
   output logic [20:0]                keyed_count_out,
   output logic                       keyed_count_valid_out
`endif
);

   localparam int WIN_SIZE   = 1 << WIN_LOG2;
   localparam int WIN_PIXELS = 1 << (2 * WIN_LOG2);
   localparam int CNT_W      = 2 * WIN_LOG2 + 1;

   localparam logic [11:0] H_LO = 12'(WIN_H0);
   localparam logic [11:0] H_HI = 12'(WIN_H0 + WIN_SIZE);
   localparam logic [10:0] V_LO = 11'(WIN_V0);
   localparam logic [10:0] V_HI = 11'(WIN_V0 + WIN_SIZE);

   // Stage 1 outputs
   logic signed [EXCESS_W-1:0] s1_excess;
   logic                       s1_valid;
   logic [10:0]                s1_hcount;
   logic [9:0]                 s1_vcount;

   // Stage 2 registers
   logic        mask_d, mask_q;
   logic        valid2_d, valid2_q;
   logic [10:0] hcount2_d, hcount2_q;
   logic [9:0]  vcount2_d, vcount2_q;

   // Calibration sequencer
   calib_state_e               state_d, state_q;
   logic signed [ACC_W-1:0]    acc_d, acc_q;
   logic [CNT_W-1:0]           cnt_d, cnt_q;
   logic signed [EXCESS_W-1:0] thresh_d, thresh_q;
   logic                       done_d, done_q;
   logic                       fail_d, fail_q;

   logic                       s1_sof;
   logic                       s1_in_window;
   logic signed [ACC_W-1:0]    acc_sum;
   logic [CNT_W-1:0]           cnt_inc;
   logic signed [ACC_W-1:0]    acc_mean;
   logic signed [EXCESS_W-1:0] thresh_new;

   green_excess_stage u_stage1 (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .valid_in   (valid_in),
      .r_in       (r_in),
      .g_in       (g_in),
      .b_in       (b_in),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .excess_out (s1_excess),
      .valid_out  (s1_valid),
      .hcount_out (s1_hcount),
      .vcount_out (s1_vcount)
   );

   // Stage 2 compare against whatever threshold is current on this cycle.
   always_comb begin
      mask_d    = (s1_excess > thresh_q) ? 1'b0 : 1'b1;
      valid2_d  = s1_valid;
      hcount2_d = s1_hcount;
      vcount2_d = s1_vcount;
   end

   // Stage 2 register; the mask rests at "keep" out of reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mask_q    <= 1'b1;
         valid2_q  <= 1'b0;
         hcount2_q <= '0;
         vcount2_q <= '0;
      end else begin
         mask_q    <= mask_d;
         valid2_q  <= valid2_d;
         hcount2_q <= hcount2_d;
         vcount2_q <= vcount2_d;
      end
   end

   // Window membership, frame start and the derived threshold candidate.
   always_comb begin
      s1_sof       = s1_valid && (s1_hcount == 11'd0) && (s1_vcount == 10'd0);
      s1_in_window = s1_valid
                  && ({1'b0, s1_hcount} >= H_LO) && ({1'b0, s1_hcount} < H_HI)
                  && ({1'b0, s1_vcount} >= V_LO) && ({1'b0, s1_vcount} < V_HI);
      acc_sum      = acc_q + $signed({{(ACC_W-EXCESS_W){s1_excess[EXCESS_W-1]}}, s1_excess});
      cnt_inc      = cnt_q + CNT_W'(1);
      acc_mean     = acc_q >>> (2 * WIN_LOG2);
      thresh_new   = clamp_thresh(acc_mean - $signed(ACC_W'(MARGIN)));
   end

   // Calibration next-state logic; a start request always restarts the run.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      thresh_d = thresh_q;
      done_d   = 1'b0;
      fail_d   = 1'b0;
      if (calib_start_in) begin
         state_d = WAIT_SOF;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            WAIT_SOF: begin
               if (s1_sof) begin
                  state_d = ACCUM;
                  if (s1_in_window) begin
                     acc_d = acc_sum;
                     cnt_d = cnt_inc;
                     if (cnt_inc == CNT_W'(WIN_PIXELS)) begin
                        state_d = APPLY;
                     end
                  end
               end
            end
            ACCUM: begin
               if (s1_sof) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
                  fail_d  = 1'b1;
               end else if (s1_in_window) begin
                  acc_d = acc_sum;
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(WIN_PIXELS)) begin
                     state_d = APPLY;
                  end
               end
            end
            APPLY: begin
               thresh_d = thresh_new;
               acc_d    = '0;
               cnt_d    = '0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Sequencer state, accumulator and threshold registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         thresh_q <= EXCESS_W'(DEFAULT_THRESH);
         done_q   <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         thresh_q <= thresh_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
      end
   end

   assign mask_out       = mask_q;
   assign valid_out      = valid2_q;
   assign hcount_out     = hcount2_q;
   assign vcount_out     = vcount2_q;
   assign threshold_out  = thresh_q;
   assign busy_out       = (state_q != IDLE);
   assign calib_done_out = done_q;
   assign calib_fail_out = fail_q;

`ifdef CHROMA_KEY_STATS_EN
   logic [20:0] kcnt_d, kcnt_q;
   logic [20:0] kout_d, kout_q;
   logic        kvalid_d, kvalid_q;
   logic        out_keyed;
   logic        out_sof;

   // Count keyed output pixels; a start-of-frame publishes and restarts the count.
   always_comb begin
      out_keyed = valid2_q && !mask_q;
      out_sof   = valid2_q && (hcount2_q == 11'd0) && (vcount2_q == 10'd0);
      kcnt_d    = kcnt_q + 21'(out_keyed);
      kout_d    = kout_q;
      kvalid_d  = 1'b0;
      if (out_sof) begin
         kout_d   = kcnt_q;
         kvalid_d = 1'b1;
         kcnt_d   = 21'(out_keyed);
      end
   end

   // Statistics registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         kcnt_q   <= '0;
         kout_q   <= '0;
         kvalid_q <= 1'b0;
      end else begin
         kcnt_q   <= kcnt_d;
         kout_q   <= kout_d;
         kvalid_q <= kvalid_d;
      end
   end

   assign keyed_count_out       = kout_q;
   assign keyed_count_valid_out = kvalid_q;
`endif

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// Self-checking bench for chroma_key_ctrl. Pixels are predicted from
// g - r - b against a modelled threshold; calibration results come from the
// window mean computed with plain arithmetic over the driven pixels.
// Building with CHROMA_KEY_STATS_EN also exercises the keyed-pixel counter.
module tb_chroma_key_ctrl;

   localparam int WIN_H0  = 576;
   localparam int WIN_V0  = 296;
   localparam int WIN_N   = 64;
   localparam int WIN_PIX = WIN_N * WIN_N;
   localparam int MARGIN  = 16;
   localparam int DEF_THR = 64;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        valid_in;
   logic [7:0]  r_in, g_in, b_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        calib_start_in;
   logic        mask_out, valid_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic [9:0]  threshold_out;
   logic        busy_out, calib_done_out, calib_fail_out;
`ifdef CHROMA_KEY_STATS_EN
   logic [20:0] keyed_count_out;
   logic        keyed_count_valid_out;
`endif

   always #5 clk_in = ~clk_in;

   chroma_key_ctrl dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .valid_in       (valid_in),
      .r_in           (r_in),
      .g_in           (g_in),
      .b_in           (b_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .calib_start_in (calib_start_in),
      .mask_out       (mask_out),
      .valid_out      (valid_out),
      .hcount_out     (hcount_out),
      .vcount_out     (vcount_out),
      .threshold_out  (threshold_out),
      .busy_out       (busy_out),
      .calib_done_out (calib_done_out),
      .calib_fail_out (calib_fail_out)
`ifdef CHROMA_KEY_STATS_EN
      ,
      .keyed_count_out       (keyed_count_out),
      .keyed_count_valid_out (keyed_count_valid_out)
`endif
   );

   typedef struct {
      logic        v;
      logic [10:0] h;
      logic [9:0]  vc;
      int          e;
   } pix_t;

   int     checks = 0;
   int     failures = 0;
   int     model_thr = DEF_THR;
   longint model_sum = 0;
   int     n_done = 0;
   int     n_fail = 0;
   int     n_stats = 0;
   int     last_stats = 0;
   bit     check_pipe = 1'b0;
   bit     check_mask = 1'b0;
   pix_t   hist[3];

   function automatic int exp_thr(input longint s);
      longint q;
      q = s / WIN_PIX;
      if ((s % WIN_PIX) != 0 && s < 0) q = q - 1;
      q = q - MARGIN;
      if (q < 0) q = 0;
      if (q > 255) q = 255;
      return int'(q);
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < 3; i++) begin
         hist[i].v = 1'b0; hist[i].h = '0; hist[i].vc = '0; hist[i].e = 0;
      end
   endtask

   // One clock: drive a pixel, then check the pixel driven two clocks earlier.
   task automatic cycle(input logic v, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic [10:0] h,
                        input logic [9:0] vc, input logic st);
      logic exp_mask;
      @(posedge clk_in);
      #1;
      valid_in = v; r_in = r; g_in = g; b_in = b;
      hcount_in = h; vcount_in = vc; calib_start_in = st;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0].v = v; hist[0].h = h; hist[0].vc = vc;
      hist[0].e = int'(g) - int'(r) - int'(b);
      @(negedge clk_in);
      if (calib_done_out === 1'b1) n_done++;
      if (calib_fail_out === 1'b1) n_fail++;
`ifdef CHROMA_KEY_STATS_EN
      if (keyed_count_valid_out === 1'b1) begin
         n_stats++;
         last_stats = int'(keyed_count_out);
      end
`endif
      if (check_pipe) begin
         checks++;
         if ({valid_out, hcount_out, vcount_out} !== {hist[2].v, hist[2].h, hist[2].vc}) begin
            failures++;
            $display("[TB] FAIL pipe_delay: got v=%0b h=%0d row=%0d, expected v=%0b h=%0d row=%0d",
                     valid_out, hcount_out, vcount_out, hist[2].v, hist[2].h, hist[2].vc);
         end
         if (check_mask) begin
            exp_mask = (hist[2].e > model_thr) ? 1'b0 : 1'b1;
            checks++;
            if (mask_out !== exp_mask) begin
               failures++;
               $display("[TB] FAIL mask: e=%0d thr=%0d got %0b expected %0b",
                        hist[2].e, model_thr, mask_out, exp_mask);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 8'($urandom), 8'($urandom), 8'($urandom),
               11'($urandom_range(1, 2000)), 10'($urandom_range(1, 1000)), 1'b0);
   endtask

   task automatic pick(input int kind, output logic [7:0] r, output logic [7:0] g,
                       output logic [7:0] b);
      case (kind)
         0: begin r = 8'd20;  g = 8'd180; b = 8'd20; end
         1: begin r = 8'd200; g = 8'd50;  b = 8'd50; end
         2: begin r = 8'd0;   g = 8'd255; b = 8'd0;  end
         3: begin
            r = 8'($urandom_range(0, 60));
            g = 8'($urandom_range(100, 255));
            b = 8'($urandom_range(0, 60));
         end
         default: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
      endcase
   endtask

   // Rows v_first..v_last over columns 574..641, with random blanking cycles.
   task automatic drive_frame(input int kind, input int v_first, input int v_last,
                              input bit sof, input int restart_row);
      logic [7:0] r, g, b;
      if (sof) cycle(1'b1, 8'd200, 8'd200, 8'd200, 11'd0, 10'd0, 1'b0);
      for (int vv = v_first; vv <= v_last; vv++) begin
         for (int hh = 574; hh <= 641; hh++) begin
            if ($urandom_range(0, 15) == 0)
               cycle(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 11'(hh), 10'(vv), 1'b0);
            pick(kind, r, g, b);
            cycle(1'b1, r, g, b, 11'(hh), 10'(vv), (vv == restart_row && hh == 600));
            if (hh >= WIN_H0 && hh < WIN_H0 + WIN_N && vv >= WIN_V0 && vv < WIN_V0 + WIN_N)
               model_sum += longint'(int'(g) - int'(r) - int'(b));
         end
      end
   endtask

   task automatic pulse_start();
      cycle(1'b0, 8'd0, 8'd0, 8'd0, 11'd5, 10'd5, 1'b1);
      idle(1);
      checks++;
      if (busy_out !== 1'b1) begin
         failures++;
         $display("[TB] FAIL busy_after_start: got %0b expected 1", busy_out);
      end
   endtask

   task automatic check_result(input string name, input int exp_done, input int exp_fail);
      checks++;
      if (n_done != exp_done) begin
         failures++;
         $display("[TB] FAIL %s_done: got %0d pulses expected %0d", name, n_done, exp_done);
      end
      checks++;
      if (n_fail != exp_fail) begin
         failures++;
         $display("[TB] FAIL %s_fail: got %0d pulses expected %0d", name, n_fail, exp_fail);
      end
      checks++;
      if (threshold_out !== 10'(model_thr)) begin
         failures++;
         $display("[TB] FAIL %s_thresh: got %0d expected %0d", name, $signed(threshold_out), model_thr);
      end
   endtask

   task automatic do_reset();
      check_pipe = 1'b0;
      rst_in = 1'b1;
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 11'($urandom), 10'($urandom), 1'b0);
      checks++;
      if ({mask_out, valid_out, hcount_out, vcount_out} !== {1'b1, 1'b0, 11'd0, 10'd0}) begin
         failures++;
         $display("[TB] FAIL reset_pipe: got m=%0b v=%0b h=%0d row=%0d expected m=1 v=0 h=0 row=0",
                  mask_out, valid_out, hcount_out, vcount_out);
      end
      checks++;
      if (threshold_out !== 10'(DEF_THR)) begin
         failures++;
         $display("[TB] FAIL reset_thresh: got %0d expected %0d", threshold_out, DEF_THR);
      end
      checks++;
      if ({busy_out, calib_done_out, calib_fail_out} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_status: got busy=%0b done=%0b fail=%0b expected 0 0 0",
                  busy_out, calib_done_out, calib_fail_out);
      end
      valid_in = 1'b0; r_in = '0; g_in = '0; b_in = '0;
      hcount_in = '0; vcount_in = '0; calib_start_in = 1'b0;
      rst_in = 1'b0;
      clear_hist();
      model_thr = DEF_THR;
      n_done = 0;
      n_fail = 0;
      check_pipe = 1'b1;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      do_reset();
      idle(4);
   endtask

   task automatic stream_table(input logic [23:0] tbl[]);
      foreach (tbl[i])
         cycle(1'b1, tbl[i][23:16], tbl[i][15:8], tbl[i][7:0],
               11'($urandom_range(1, 2000)), 10'($urandom_range(1, 1000)), 1'b0);
   endtask

   task automatic test_mask_basic();
      logic [23:0] tbl[];
      $display("[TB] test_mask_basic");
      check_mask = 1'b1;
      tbl = '{{8'd10, 8'd200, 8'd10}, {8'd200, 8'd200, 8'd200}, {8'd0, 8'd64, 8'd0},
              {8'd0, 8'd65, 8'd0}, {8'd255, 8'd0, 8'd255}, {8'd0, 8'd255, 8'd0}};
      stream_table(tbl);
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
               11'($urandom_range(1, 2000)), 10'($urandom_range(1, 1000)), 1'b0);
      idle(3);
   endtask

   task automatic test_calib_fail();
      $display("[TB] test_calib_fail");
      check_mask = 1'b1;
      n_done = 0; n_fail = 0;
      pulse_start();
      drive_frame(4, 294, 305, 1'b1, -1);
      cycle(1'b1, 8'd200, 8'd200, 8'd200, 11'd0, 10'd0, 1'b0);
      idle(6);
      check_result("calib_fail", 0, 1);
      checks++;
      if (busy_out !== 1'b0) begin
         failures++;
         $display("[TB] FAIL calib_fail_busy: got %0b expected 0", busy_out);
      end
   endtask

   task automatic calibrate(input int kind, input string name);
      $display("[TB] calibrate %s", name);
      check_mask = 1'b0;
      n_done = 0; n_fail = 0;
      model_sum = 0;
      pulse_start();
      drive_frame(kind, 294, 361, 1'b1, -1);
      idle(8);
      model_thr = exp_thr(model_sum);
      check_result(name, 1, 0);
      checks++;
      if (busy_out !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s_busy: got %0b expected 0", name, busy_out);
      end
      idle(2);
      check_mask = 1'b1;
   endtask

   task automatic test_mask_after_calib();
      logic [23:0] tbl[];
      $display("[TB] test_mask_after_calib");
      check_mask = 1'b1;
      tbl = '{{8'd30, 8'd170, 8'd20}, {8'd10, 8'd200, 8'd10},
              {8'd0, 8'd124, 8'd0}, {8'd0, 8'd125, 8'd0}};
      stream_table(tbl);
      for (int i = 0; i < 200; i++)
         cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
               11'($urandom_range(1, 2000)), 10'($urandom_range(1, 1000)), 1'b0);
      idle(3);
   endtask

   task automatic test_restart();
      $display("[TB] test_restart");
      check_mask = 1'b0;
      n_done = 0; n_fail = 0;
      pulse_start();
      drive_frame(2, 294, 361, 1'b1, 320);
      idle(8);
      check_result("restart_aborted", 0, 0);
      checks++;
      if (busy_out !== 1'b1) begin
         failures++;
         $display("[TB] FAIL restart_busy: got %0b expected 1", busy_out);
      end
      model_sum = 0;
      drive_frame(0, 294, 361, 1'b1, -1);
      idle(8);
      model_thr = exp_thr(model_sum);
      check_result("restart_complete", 1, 0);
      idle(2);
      check_mask = 1'b1;
   endtask

   task automatic test_reset_mid_calib();
      $display("[TB] test_reset_mid_calib");
      check_mask = 1'b0;
      pulse_start();
      drive_frame(2, 294, 320, 1'b1, -1);
      do_reset();
      check_mask = 1'b1;
      drive_frame(2, 321, 361, 1'b0, -1);
      idle(8);
      check_result("reset_mid_calib", 0, 0);
   endtask

   task automatic test_back_to_back();
      $display("[TB] test_back_to_back");
      check_mask = 1'b1;
      for (int i = 0; i < 500; i++)
         cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
               11'($urandom_range(1, 2000)), 10'($urandom_range(1, 1000)), 1'b0);
      idle(3);
   endtask

`ifdef CHROMA_KEY_STATS_EN
   task automatic test_stats();
      $display("[TB] test_stats");
      check_mask = 1'b1;
      cycle(1'b1, 8'd200, 8'd200, 8'd200, 11'd0, 10'd0, 1'b0);
      idle(4);
      n_stats = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle(1'b1, 8'd0, 8'd255, 8'd0, 11'(1 + i % 600), 10'(1 + i / 600), 1'b0);
         if (i % 10 == 0) begin
            cycle(1'b1, 8'd200, 8'd200, 8'd200, 11'(700), 10'(1 + i / 600), 1'b0);
            cycle(1'b0, 8'd0, 8'd255, 8'd0, 11'(701), 10'(1 + i / 600), 1'b0);
         end
      end
      cycle(1'b1, 8'd200, 8'd200, 8'd200, 11'd0, 10'd0, 1'b0);
      idle(4);
      checks++;
      if (n_stats != 1 || last_stats != 1000) begin
         failures++;
         $display("[TB] FAIL keyed_count: got %0d (pulses %0d) expected 1000 (pulses 1)",
                  last_stats, n_stats);
      end
   endtask
`endif

   initial begin
      rst_in = 1'b1;
      valid_in = 1'b0; r_in = '0; g_in = '0; b_in = '0;
      hcount_in = '0; vcount_in = '0; calib_start_in = 1'b0;
      clear_hist();
      test_reset();
`ifdef CHROMA_KEY_STATS_EN
      test_stats();
`endif
      test_mask_basic();
      test_calib_fail();
      calibrate(0, "uniform_140");
      test_mask_after_calib();
      calibrate(1, "clamp_low");
      calibrate(2, "pure_green");
      test_restart();
      calibrate(3, "random_window");
      test_back_to_back();
      test_reset_mid_calib();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
